// File: rtl/lfsr_pkg.sv
// Shared types and default feedback tap masks for the LFSR random number generator.
package lfsr_pkg;

   typedef enum logic [1:0] {IDLE, GEN, DONE} lfsr_fsm_t;

   localparam logic [3:0]  TAPS_W4  = 4'b0011;
   localparam logic [7:0]  TAPS_W8  = 8'b0001_1101;
   localparam logic [9:0]  TAPS_W10 = 10'b00_0000_1001;
   localparam logic [15:0] TAPS_W16 = 16'b0000_0000_0010_1101;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci XNOR LFSR state register with seed load, all-ones lock-up recovery
// and period detection against the last loaded (or reset) value.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int unsigned          WIDTH = 10,
   parameter logic [WIDTH-1:0]     TAPS  = TAPS_W10,
   parameter logic [WIDTH-1:0]     SEED  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_seed,
   input  logic             i_step,
   output logic [WIDTH-1:0] o_state,
   output logic             o_lockup,
   output logic             o_period_done,
   output logic             o_replace
);

   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] r_ref;
   logic             r_lockup;
   logic             r_period;
   logic             w_fb;
   logic             w_allones;
   logic [WIDTH-1:0] w_next;

   assign w_fb      = ~^(r_state & TAPS);
   assign w_next    = {w_fb, r_state[WIDTH-1:1]};
   assign w_allones = &r_state;
   // State is overwritten this edge (load or recovery), so no step is taken.
   assign o_replace = i_load | w_allones;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= SEED;
         r_ref    <= SEED;
         r_lockup <= 1'b0;
         r_period <= 1'b0;
      end else begin
         r_lockup <= 1'b0;
         r_period <= 1'b0;
         if (i_load) begin
            r_state <= i_seed;
            r_ref   <= i_seed;
         end else if (w_allones) begin
            r_state  <= SEED;
            r_lockup <= 1'b1;
         end else if (i_step) begin
            r_state  <= w_next;
            r_period <= (w_next == r_ref);
         end
      end
   end

   assign o_state       = r_state;
   assign o_lockup      = r_lockup;
   assign o_period_done = r_period;

endmodule

// File: rtl/lfsr_rng.sv
// LFSR random number generator: free-running stepping plus a ready/valid draw
// port that shifts OUT_BITS fresh serial bits out of the LFSR per request.
module lfsr_rng
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH    = 10,
   parameter logic [WIDTH-1:0] TAPS     = TAPS_W10,
   parameter logic [WIDTH-1:0] SEED     = '0,
   parameter int unsigned      OUT_BITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                load,
   input  logic [WIDTH-1:0]    seed_in,
   input  logic                req_valid,
   output logic                req_ready,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [OUT_BITS-1:0] rsp_data,
   output logic [WIDTH-1:0]    state_out,
   output logic                lockup,
   output logic                period_done
);

   localparam int unsigned    CW   = $clog2(OUT_BITS + 1);
   localparam logic [CW-1:0]  LAST = CW'(OUT_BITS - 1);

   lfsr_fsm_t           r_fsm, w_fsm_nxt;
   logic [CW-1:0]       r_cnt, w_cnt_nxt;
   logic [OUT_BITS-1:0] r_rsp_data, w_data_nxt;
   logic [OUT_BITS-1:0] w_shifted;
   logic [WIDTH-1:0]    w_state;
   logic                w_step;
   logic                w_replace;

   assign w_step = (r_fsm == GEN) || (en && (r_fsm != GEN));

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_core (
      .clk           (clk),
      .reset         (reset),
      .i_load        (load),
      .i_seed        (seed_in),
      .i_step        (w_step),
      .o_state       (w_state),
      .o_lockup      (lockup),
      .o_period_done (period_done),
      .o_replace     (w_replace)
   );

   if (OUT_BITS == 1) begin : g_one
      assign w_shifted = w_state[0];
   end else begin : g_many
      assign w_shifted = {r_rsp_data[OUT_BITS-2:0], w_state[0]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fsm      <= IDLE;
         r_cnt      <= '0;
         r_rsp_data <= '0;
      end else begin
         r_fsm      <= w_fsm_nxt;
         r_cnt      <= w_cnt_nxt;
         r_rsp_data <= w_data_nxt;
      end
   end

   always_comb begin
      w_fsm_nxt  = r_fsm;
      w_cnt_nxt  = r_cnt;
      w_data_nxt = r_rsp_data;
      case (r_fsm)
         IDLE: begin
            if (req_valid) begin
               w_fsm_nxt  = GEN;
               w_cnt_nxt  = '0;
               w_data_nxt = '0;
            end
         end
         GEN: begin
            // A replaced state carries no fresh bit; wait for the next step.
            if (!w_replace) begin
               w_data_nxt = w_shifted;
               w_cnt_nxt  = r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  w_fsm_nxt = DONE;
               end
            end
         end
         DONE: begin
            if (rsp_ready) begin
               w_fsm_nxt = IDLE;
            end
         end
         default: w_fsm_nxt = IDLE;
      endcase
   end

   assign req_ready = (r_fsm == IDLE);
   assign rsp_valid = (r_fsm == DONE);
   assign rsp_data  = r_rsp_data;
   assign state_out = w_state;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng: default 10-bit instance plus a 4-bit instance for period checks.
module tb_lfsr_rng;

   logic       clk = 1'b0;
   logic       reset;
   logic       en, load, req_valid, rsp_ready;
   logic [9:0] seed_in;
   logic       req_ready, rsp_valid, lockup, period_done;
   logic [3:0] rsp_data;
   logic [9:0] state_out;

   logic       en4;
   logic       req_ready4, rsp_valid4, lockup4, period_done4;
   logic [3:0] rsp_data4;
   logic [3:0] state_out4;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   lfsr_rng u_dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .load        (load),
      .seed_in     (seed_in),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .state_out   (state_out),
      .lockup      (lockup),
      .period_done (period_done)
   );

   lfsr_rng #(
      .WIDTH    (4),
      .TAPS     (4'b0011),
      .SEED     (4'h0),
      .OUT_BITS (4)
   ) u_dut4 (
      .clk         (clk),
      .reset       (reset),
      .en          (en4),
      .load        (1'b0),
      .seed_in     (4'h0),
      .req_valid   (1'b0),
      .req_ready   (req_ready4),
      .rsp_valid   (rsp_valid4),
      .rsp_ready   (1'b0),
      .rsp_data    (rsp_data4),
      .state_out   (state_out4),
      .lockup      (lockup4),
      .period_done (period_done4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [9:0] free_seq [8];
   logic [3:0] seq4     [15];

   initial begin
      free_seq = '{10'h200, 10'h300, 10'h380, 10'h3C0, 10'h3E0, 10'h3F0, 10'h3F8, 10'h1FC};
      seq4     = '{4'h8, 4'hC, 4'hE, 4'h7, 4'hB, 4'hD, 4'h6, 4'h3,
                   4'h9, 4'h4, 4'hA, 4'h5, 4'h2, 4'h1, 4'h0};

      reset = 1'b1; en = 1'b0; load = 1'b0; seed_in = '0;
      req_valid = 1'b0; rsp_ready = 1'b0; en4 = 1'b0;

      #3;
      chk("rst_state", 32'(state_out), 32'h000);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h1);
      chk("rst_rsp_data", 32'(rsp_data), 32'h0);
      chk("rst_lockup", 32'(lockup), 32'h0);
      chk("rst_period", 32'(period_done), 32'h0);
      #4;
      reset = 1'b0;

      // Free-run stepping from the all-zero seed.
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("free_step%0d", i), 32'(state_out), 32'(free_seq[i]));
      end
      en = 1'b0;

      // Loading all-ones triggers recovery one cycle later.
      load = 1'b1; seed_in = 10'h3FF;
      tick();
      load = 1'b0;
      chk("load_ones_state", 32'(state_out), 32'h3FF);
      chk("load_ones_lockup", 32'(lockup), 32'h0);
      tick();
      chk("recover_lockup", 32'(lockup), 32'h1);
      chk("recover_state", 32'(state_out), 32'h000);
      tick();
      chk("lockup_pulse_end", 32'(lockup), 32'h0);
      chk("recover_hold", 32'(state_out), 32'h000);

      // Draw from state 0 with the consumer stalled.
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("gen_req_ready", 32'(req_ready), 32'h0);
      chk("gen_rsp_valid", 32'(rsp_valid), 32'h0);
      tick(); tick(); tick();
      chk("gen3_state", 32'(state_out), 32'h380);
      chk("gen3_valid", 32'(rsp_valid), 32'h0);
      tick();
      chk("done_valid", 32'(rsp_valid), 32'h1);
      chk("done_data", 32'(rsp_data), 32'h0);
      chk("done_state", 32'(state_out), 32'h3C0);
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("hold_valid%0d", i), 32'(rsp_valid), 32'h1);
         chk($sformatf("hold_state%0d", i), 32'(state_out), 32'h3C0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("accept_valid", 32'(rsp_valid), 32'h0);
      chk("accept_req_ready", 32'(req_ready), 32'h1);

      // Load 0x155 after two captures; draw finishes from the new state.
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      chk("mid_pre_load", 32'(state_out), 32'h3F0);
      load = 1'b1; seed_in = 10'h155;
      tick();
      load = 1'b0;
      chk("mid_load_state", 32'(state_out), 32'h155);
      chk("mid_load_valid", 32'(rsp_valid), 32'h0);
      tick();
      chk("mid_g4_state", 32'(state_out), 32'h0AA);
      chk("mid_g4_valid", 32'(rsp_valid), 32'h0);
      tick();
      chk("mid_done_valid", 32'(rsp_valid), 32'h1);
      chk("mid_done_data", 32'(rsp_data), 32'h2);
      chk("mid_done_state", 32'(state_out), 32'h055);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("freeze%0d", i), 32'(state_out), 32'h055);
      end

      // Draw with mixed bits checks shift order.
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("mix_valid", 32'(rsp_valid), 32'h1);
      chk("mix_data", 32'(rsp_data), 32'hA);
      chk("mix_state", 32'(state_out), 32'h005);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // 4-bit instance: maximal period 15, never all-ones.
      en4 = 1'b1;
      for (int i = 0; i < 45; i++) begin
         tick();
         chk($sformatf("w4_state%0d", i), 32'(state_out4), 32'(seq4[i % 15]));
         chk($sformatf("w4_period%0d", i), 32'(period_done4), ((i % 15) == 14) ? 32'h1 : 32'h0);
      end
      en4 = 1'b0;

      // Asynchronous reset while a result waits in DONE.
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
      chk("pre_rst_data", 32'(rsp_data), 32'hA);
      chk("pre_rst_state", 32'(state_out), 32'h280);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", 32'(rsp_valid), 32'h0);
      chk("async_rst_state", 32'(state_out), 32'h000);
      chk("async_rst_data", 32'(rsp_data), 32'h0);
      chk("async_rst_req_ready", 32'(req_ready), 32'h1);
      #3;
      reset = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
